uart_autobaud: RTL and testbench

//  Measures the baud rate of an incoming 0x55 sync character on rxd.

---
 rtl/uart_autobaud.sv | 153 +++++++++++++++
 tb/tb_uart_autobaud.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_autobaud: measures an incoming 0x55 sync character and derives the    |
// | UART prescale (clk cycles per bit / 8). Macro AUTOBAUD_CHECK_EN adds a     |
// | per-interval consistency check that rejects non-0x55 bytes.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_autobaud #(
  parameter int          CNT_WIDTH     = 22,
  parameter logic [15:0] PRESCALE_INIT = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        start,
  output logic [15:0] prescale,
  output logic        prescale_valid,
  output logic        busy,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_ST, S_MEASURE, S_STOP, S_CALC, S_DONE, S_ERROR
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH:0]   ROUND   = (CNT_WIDTH+1)'(32);

  state_t                state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic                  rxd_prev_q, rxd_prev_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [2:0]            edge_n_q, edge_n_d;
  logic [15:0]           prescale_q, prescale_d;
  logic                  rxd_s, fall;
  logic [CNT_WIDTH:0]    sum_w;
  logic [31:0]           res_w;
`ifdef AUTOBAUD_CHECK_EN
  logic [CNT_WIDTH-1:0]  ivl_q, ivl_d, i0_q, i0_d;
  logic [CNT_WIDTH-1:0]  ivl_len, ivl_diff;
  logic                  ivl_ok;
`endif

  assign rxd_s = sync_q[1];
  assign fall  = rxd_prev_q & ~rxd_s;

  // Rounded divide by 64: 8 bit times measured, prescale is bit time / 8.
  assign sum_w = {1'b0, cnt_q} + ROUND;
  assign res_w = 32'(sum_w >> 6);

`ifdef AUTOBAUD_CHECK_EN
  assign ivl_len  = ivl_q + CNT_ONE;
  assign ivl_diff = (ivl_len > i0_q) ? (ivl_len - i0_q) : (i0_q - ivl_len);
  assign ivl_ok   = (ivl_diff <= (i0_q >> 2));
`endif

  always_comb begin
    sync_d     = {sync_q[0], rxd};
    rxd_prev_d = rxd_s;
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_n_d   = edge_n_q;
    prescale_d = prescale_q;
`ifdef AUTOBAUD_CHECK_EN
    ivl_d      = ivl_q;
    i0_d       = i0_q;
`endif
    case (state_q)
      S_IDLE:    if (start) state_d = S_ARM;
      S_ARM:     if (rxd_s) state_d = S_WAIT_ST;
      S_WAIT_ST: begin
        if (fall) begin
          cnt_d    = '0;
          edge_n_d = 3'd1;
`ifdef AUTOBAUD_CHECK_EN
          ivl_d    = '0;
`endif
          state_d  = S_MEASURE;
        end
      end
      S_MEASURE: begin
        // Timeout takes priority so the counter can never wrap.
        if (cnt_q == CNT_MAX) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
`ifdef AUTOBAUD_CHECK_EN
          ivl_d = ivl_q + CNT_ONE;
`endif
          if (fall) begin
            edge_n_d = edge_n_q + 3'd1;
            if (edge_n_q == 3'd4) state_d = S_STOP;
`ifdef AUTOBAUD_CHECK_EN
            ivl_d = '0;
            if (edge_n_q == 3'd1) i0_d = ivl_len;
            else if (!ivl_ok)     state_d = S_ERROR;
`endif
          end
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_MAX) state_d = S_ERROR;
        else if (rxd_s)       state_d = S_CALC;
      end
      S_CALC: begin
        if (res_w == 32'd0 || res_w > 32'h0000_FFFF) begin
          state_d = S_ERROR;
        end else begin
          prescale_d = res_w[15:0];
          state_d    = S_DONE;
        end
      end
      S_DONE:    state_d = S_IDLE;
      S_ERROR:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sync_q     <= 2'b11;
      rxd_prev_q <= 1'b1;
      cnt_q      <= '0;
      edge_n_q   <= 3'd0;
      prescale_q <= PRESCALE_INIT;
`ifdef AUTOBAUD_CHECK_EN
      ivl_q      <= '0;
      i0_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      rxd_prev_q <= rxd_prev_d;
      cnt_q      <= cnt_d;
      edge_n_q   <= edge_n_d;
      prescale_q <= prescale_d;
`ifdef AUTOBAUD_CHECK_EN
      ivl_q      <= ivl_d;
      i0_q       <= i0_d;
`endif
    end
  end

  // prescale_q is loaded on the CALC->DONE edge, so the valid pulse coincides with the new value.
  assign prescale       = prescale_q;
  assign prescale_valid = (state_q == S_DONE);
  assign error          = (state_q == S_ERROR);
  assign busy           = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_autobaud.sv
`default_nettype none
// tb_uart_autobaud: directed calibrations; expected prescale derived from the line
// waveform (fall positions in bit times) rather than from the counter pipeline.
module tb_uart_autobaud;

  logic        clk = 1'b0;
  logic        rst, rxd, start, rxd12, start12;
  logic [15:0] prescale, prescale12;
  logic        prescale_valid, busy, error;
  logic        prescale_valid12, busy12, error12;

  always #5 clk = ~clk;

  uart_autobaud u_dut (
    .clk(clk), .rst(rst), .rxd(rxd), .start(start),
    .prescale(prescale), .prescale_valid(prescale_valid), .busy(busy), .error(error)
  );

  uart_autobaud #(.CNT_WIDTH(12), .PRESCALE_INIT(16'd7)) u_dut12 (
    .clk(clk), .rst(rst), .rxd(rxd12), .start(start12),
    .prescale(prescale12), .prescale_valid(prescale_valid12), .busy(busy12), .error(error12)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line-level model: frame bytes, find falling edges, total span fall#1..fall#5.
  function automatic void model(input logic [7:0] b0, input logic [7:0] b1, input int nb,
                                input int p, output bit err, output logic [15:0] val);
    bit     lvl[$];
    int     f[$];
    longint cnt, res;
    lvl.push_back(1'b1);
    for (int k = 0; k < nb; k++) begin
      logic [7:0] b;
      b = (k == 0) ? b0 : b1;
      lvl.push_back(1'b0);
      for (int j = 0; j < 8; j++) lvl.push_back(b[j]);
      lvl.push_back(1'b1);
    end
    for (int i = 1; i < lvl.size(); i++)
      if (lvl[i-1] && !lvl[i]) f.push_back(i);
    err = 1'b0;
    val = 16'd0;
    if (f.size() < 5) begin
      err = 1'b1;
      return;
    end
    cnt = longint'(f[4] - f[0]) * p;
    res = (cnt + 32) / 64;
    if (res == 0 || res > 65535) err = 1'b1;
    else val = res[15:0];
`ifdef AUTOBAUD_CHECK_EN
    for (int k = 1; k <= 3; k++) begin
      longint i0, ik;
      i0 = longint'(f[1] - f[0]) * p;
      ik = longint'(f[k+1] - f[k]) * p;
      if (((ik > i0) ? ik - i0 : i0 - ik) > i0 / 4) err = 1'b1;
    end
`endif
  endfunction

  // Compare process state: 0 = no pulse due, 1 = prescale update due, 2 = error due.
  int          exp_kind = 0;
  logic [15:0] exp_prescale = 16'd1;
  logic [15:0] exp_next = 16'd0;
  bit          prev_pulse = 1'b0;
  bit          idle_only = 1'b0;
  int          n_ok = 0, n_err = 0, n_err12 = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_prescale = 16'd1;
      exp_kind     = 0;
      prev_pulse   = 1'b0;
    end else begin
      if (prev_pulse) chk("busy_drop_after_pulse", busy, 0);
      if (idle_only)  chk("busy_without_start", busy, 0);
      chk("valid_with_error", prescale_valid & error, 0);
      if (prescale_valid) begin
        chk("valid_due", exp_kind, 1);
        chk("prescale_new", prescale, exp_next);
        chk("busy_in_done", busy, 1);
        exp_prescale = exp_next;
        exp_kind     = 0;
        n_ok++;
      end else begin
        chk("prescale_hold", prescale, exp_prescale);
      end
      if (error) begin
        chk("error_due", exp_kind, 2);
        chk("busy_in_error", busy, 1);
        exp_kind = 0;
        n_err++;
      end
      prev_pulse = prescale_valid | error;
      chk("dut12_prescale_hold", prescale12, 16'd7);
      chk("dut12_no_valid", prescale_valid12, 0);
      if (error12) n_err12++;
    end
  end

  task automatic send(input logic [7:0] b, input int p, input bit last, input bit poke);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < (last ? 9 : 10); i++) begin
      rxd = frame[i];
      for (int c = 0; c < p; c++) begin
        if (poke && i == 4 && c == 0) start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    rxd = 1'b1;
  endtask

  task automatic run_cal(input string name, input logic [7:0] b0, input logic [7:0] b1,
                         input int nb, input int p, input int pre_low, input bit poke_start,
                         input bit done_poke, input bit chk_lat, input bit lit_err,
                         input logic [15:0] lit_val);
    bit          e;
    logic [15:0] v;
    int          ok0, er0, lat;
    ok0 = n_ok;
    er0 = n_err;
    model(b0, b1, nb, p, e, v);
    chk({name, "_model_err"}, e, lit_err);
    if (!lit_err) chk({name, "_model_val"}, v, lit_val);
    exp_next = v;
    exp_kind = e ? 2 : 1;
    if (pre_low > 0) begin
      rxd = 1'b0;
      repeat (4) tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_busy_after_start"}, busy, 1);
    if (pre_low > 0) begin
      repeat (pre_low) tick();
      chk({name, "_arm_holds_busy"}, busy, 1);
      rxd = 1'b1;
      repeat (10) tick();
    end
    if (nb > 1) send(b0, p, 1'b0, poke_start);
    send((nb > 1) ? b1 : b0, p, 1'b1, (nb > 1) ? 1'b0 : poke_start);
    lat = 0;
    while (!(prescale_valid | error) && n_ok == ok0 && n_err == er0 && lat < 200) begin
      tick();
      lat++;
    end
    if (chk_lat) chk({name, "_stop_to_done_cycles"}, lat, 4);
    if (done_poke) begin
      chk({name, "_in_done_for_poke"}, prescale_valid, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({name, "_start_in_done_ignored"}, busy, 0);
      tick();
      chk({name, "_still_idle"}, busy, 0);
    end else begin
      for (int i = 0; i < 10 && busy; i++) tick();
      chk({name, "_busy_released"}, busy, 0);
    end
    repeat (2) tick();
    chk({name, "_valid_pulses"}, n_ok - ok0, e ? 0 : 1);
    chk({name, "_error_pulses"}, n_err - er0, e ? 1 : 0);
  endtask

  initial begin
    int lat;
    rst = 1'b1; rxd = 1'b1; start = 1'b0; rxd12 = 1'b1; start12 = 1'b0;
    repeat (3) tick();
    chk("rst_prescale", prescale, 16'd1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", prescale_valid, 0);
    chk("rst_error", error, 0);
    chk("rst_prescale12", prescale12, 16'd7);
    rst = 1'b0;
    tick();

    // No start: sync byte must be ignored.
    idle_only = 1'b1;
    send(8'h55, 32, 1'b1, 1'b0);
    repeat (20) tick();
    idle_only = 1'b0;
    chk("idle_no_valid", n_ok, 0);
    chk("idle_no_error", n_err, 0);

    run_cal("p32",  8'h55, 8'h00, 1, 32,  0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd4);
    run_cal("p800", 8'h55, 8'h00, 1, 800, 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd100);
    run_cal("p64_low", 8'h55, 8'h00, 1, 64, 50, 1'b0, 1'b0, 1'b1, 1'b0, 16'd8);

    // Narrow counter: one falling edge then a stuck-low line must time out.
    start12 = 1'b1;
    tick();
    start12 = 1'b0;
    chk("t12_busy", busy12, 1);
    repeat (3) tick();
    rxd12 = 1'b0;
    lat = 0;
    while (!error12 && lat < 4300) begin
      tick();
      lat++;
    end
    n_vec++;
    if (!(lat >= 4097 && lat <= 4100)) begin
      n_bad++;
      $display("FAIL t12_timeout_latency: got %0d cycles, expected 4097..4100", lat);
    end
    rxd12 = 1'b1;
    repeat (3) tick();
    chk("t12_error_pulses", n_err12, 1);
    chk("t12_busy_released", busy12, 0);

`ifdef AUTOBAUD_CHECK_EN
    run_cal("x15", 8'h15, 8'hFF, 2, 32, 0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
`else
    run_cal("x15", 8'h15, 8'hFF, 2, 32, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);
`endif
    run_cal("p3_zero", 8'h55, 8'h00, 1, 3, 0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    run_cal("p4_min",  8'h55, 8'h00, 1, 4, 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
    run_cal("p40",     8'h55, 8'h00, 1, 40, 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5);

    // Reset mid-calibration discards state and restores the initial prescale.
    start = 1'b1;
    tick();
    start = 1'b0;
    rxd = 1'b0;
    repeat (40) tick();
    rst = 1'b1;
    repeat (2) tick();
    chk("midrst_prescale", prescale, 16'd1);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    rxd = 1'b1;
    repeat (5) tick();
    chk("after_rst_prescale", prescale, 16'd1);
    run_cal("p48", 8'h55, 8'h00, 1, 48, 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
